// File: rtl/wb_gpio_if.sv
// Wishbone classic-pipelined bus bundle shared by the J1 data-bus peripherals.
interface if_wb #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
) ();
    logic          clk;
    logic          rst;
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_i;
    logic [DW-1:0] dat_o;
    logic          ack;
    logic          stall;

    modport slave (
        input  clk, rst, cyc, stb, we, adr, dat_i,
        output dat_o, ack, stall
    );

    modport master (
        input  clk, rst, dat_o, ack, stall,
        output cyc, stb, we, adr, dat_i
    );
endinterface

// File: rtl/wb_gpio.sv
// Multi-port GPIO Wishbone slave: output/OE registers, synchronised inputs,
// atomic set/clear and per-bit edge interrupts merged into one irq line.
module wb_gpio #(
    parameter int unsigned N_PORTS     = 2,
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    if_wb.slave                      wb,
    output logic [N_PORTS*WIDTH-1:0] io_out,
    output logic [N_PORTS*WIDTH-1:0] io_oe,
    input  logic [N_PORTS*WIDTH-1:0] io_in,
    output logic                     irq
);
    // Port field is wide enough to encode N_PORTS itself, so that index decodes as unmapped.
    localparam int unsigned PSEL_W  = $clog2(N_PORTS + 1);
    localparam int unsigned IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned PRIME_N = SYNC_STAGES + 1;
    localparam int unsigned CNT_W   = $clog2(PRIME_N + 1);
    localparam int unsigned NW      = N_PORTS * WIDTH;

    logic [N_PORTS-1:0][WIDTH-1:0] out_q, out_d, oe_q, oe_d, ien_q, ien_d;
    logic [N_PORTS-1:0][WIDTH-1:0] stat_q, stat_d, edge_q, edge_d, pin_p;
    logic [SYNC_STAGES-1:0][NW-1:0] sync_q, sync_d;
    logic [NW-1:0]    prev_q, prev_d, pin_s, edge_flat, hit;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d, irq_q, irq_d;
    logic [WIDTH-1:0] dat_q, dat_d;
    logic             valid, psel_ok, prime_done;
    logic [PSEL_W-1:0] psel;
    logic [IDX_W-1:0]  pidx;
    logic              unused_ok;

    assign valid      = wb.cyc & wb.stb;
    assign psel       = wb.adr[3 +: PSEL_W];
    assign pidx       = IDX_W'(psel);
    assign psel_ok    = (32'(psel) < N_PORTS);
    assign pin_s      = sync_q[SYNC_STAGES-1];
    assign pin_p      = pin_s;
    assign edge_flat  = edge_q;
    assign prime_done = (cnt_q == CNT_W'(PRIME_N));
    assign hit        = (pin_s & ~prev_q & ~edge_flat) | (~pin_s & prev_q & edge_flat);
    assign unused_ok  = ^{wb.adr, wb.clk, wb.rst};

    assign wb.ack   = ack_q;
    assign wb.dat_o = dat_q;
    assign wb.stall = 1'b0;
    assign io_out   = out_q;
    assign io_oe    = oe_q;
    assign irq      = irq_q;

    // Next-state: bus writes, edge capture (set beats W1C), read data and irq.
    always_comb begin
        out_d  = out_q;
        oe_d   = oe_q;
        ien_d  = ien_q;
        stat_d = stat_q;
        edge_d = edge_q;
        dat_d  = dat_q;
        ack_d  = valid;
        sync_d = {sync_q[SYNC_STAGES-2:0], io_in};
        prev_d = pin_s;
        cnt_d  = prime_done ? cnt_q : cnt_q + CNT_W'(1);

        if (valid && wb.we && psel_ok) begin
            case (wb.adr[2:0])
                3'd0:    out_d[pidx]  = wb.dat_i;
                3'd1:    oe_d[pidx]   = wb.dat_i;
                3'd3:    ien_d[pidx]  = wb.dat_i;
                3'd4:    stat_d[pidx] = stat_q[pidx] & ~wb.dat_i;
                3'd5:    edge_d[pidx] = wb.dat_i;
                3'd6:    out_d[pidx]  = out_q[pidx] | wb.dat_i;
                3'd7:    out_d[pidx]  = out_q[pidx] & ~wb.dat_i;
                default: ;
            endcase
        end

        if (prime_done) begin
            stat_d = stat_d | hit;
        end

        if (valid && !wb.we) begin
            dat_d = '0;
            if (psel_ok) begin
                case (wb.adr[2:0])
                    3'd0:    dat_d = out_q[pidx];
                    3'd1:    dat_d = oe_q[pidx];
                    3'd2:    dat_d = pin_p[pidx];
                    3'd3:    dat_d = ien_q[pidx];
                    3'd4:    dat_d = stat_q[pidx];
                    3'd5:    dat_d = edge_q[pidx];
                    default: dat_d = '0;
                endcase
            end
        end

        irq_d = |(stat_q & ien_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            oe_q   <= '0;
            ien_q  <= '0;
            stat_q <= '0;
            edge_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
            cnt_q  <= '0;
            ack_q  <= 1'b0;
            dat_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            oe_q   <= oe_d;
            ien_q  <= ien_d;
            stat_q <= stat_d;
            edge_q <= edge_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
            ack_q  <= ack_d;
            dat_q  <= dat_d;
            irq_q  <= irq_d;
        end
    end
endmodule
